// File: rtl/down_counter.sv
// rtl/down_counter.sv - 8-bit loadable down counter with serial-fill reload register
// Counts Q down to zero, then reloads from S while S keeps shifting in serin.
module down_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       en,
  input  logic [7:0] dta,
  input  logic       serin,
  output logic [7:0] Qo,
  output logic       serout,
  output logic       Co
);

  logic [7:0] q;
  logic [7:0] s;
  logic       q_zero;

  assign q_zero = (q == 8'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= 8'd0;
      s <= 8'd0;
    end else if (en) begin
      if (load) begin
        q <= dta;
        s <= dta;
      end else begin
        s <= {s[6:0], serin};
        // Reload takes the pre-shift S, so the counter never wraps to 0xFF.
        q <= q_zero ? s : q - 8'd1;
      end
    end
  end

  assign Qo     = q;
  assign serout = s[7];
  assign Co     = en & ~load & q_zero;

endmodule

// File: tb/tb_down_counter.sv
// tb/tb_down_counter.sv - table-driven bench for down_counter
module tb_down_counter;

  logic       clk;
  logic       rst;
  logic       load;
  logic       en;
  logic [7:0] dta;
  logic       serin;
  logic [7:0] Qo;
  logic       serout;
  logic       Co;

  int checks;
  int errors;

  typedef struct {
    logic       en;
    logic       load;
    logic [7:0] dta;
    logic       serin;
    logic       co;
    logic [7:0] q;
    logic       so;
  } vec_t;

  vec_t vecs[$];

  down_counter dut (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .en     (en),
    .dta    (dta),
    .serin  (serin),
    .Qo     (Qo),
    .serout (serout),
    .Co     (Co)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic e, input logic l, input logic [7:0] d, input logic si,
                     input logic co, input logic [7:0] q, input logic so);
    vec_t v;
    v.en = e; v.load = l; v.dta = d; v.serin = si;
    v.co = co; v.q = q; v.so = so;
    vecs.push_back(v);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0; en = 1'b1; load = 1'b1; dta = 8'hB0; serin = 1'b0;

    // Reset held: loads are ignored.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("reset_q", Qo, 8'h00);
      chk("reset_so", {7'd0, serout}, 8'h00);
    end
    chk("reset_co", {7'd0, Co}, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("release_q", Qo, 8'hB0);
    chk("release_so", {7'd0, serout}, 8'h01);

    //   en load dta  si  co  q     so
    add(1, 1, 8'h0B, 0, 0, 8'h0B, 0);
    add(1, 0, 8'hFF, 1, 0, 8'h0A, 0);
    add(1, 0, 8'hFF, 0, 0, 8'h09, 0);
    add(1, 0, 8'hFF, 0, 0, 8'h08, 0);
    add(1, 0, 8'hFF, 0, 0, 8'h07, 1);
    add(1, 0, 8'hFF, 0, 0, 8'h06, 0);
    add(1, 0, 8'hFF, 1, 0, 8'h05, 1);
    add(1, 0, 8'hFF, 0, 0, 8'h04, 1);
    add(1, 0, 8'hFF, 1, 0, 8'h03, 1);  // S = 0x85
    add(1, 0, 8'hFF, 1, 0, 8'h02, 0);
    add(1, 0, 8'hFF, 1, 0, 8'h01, 0);
    add(1, 0, 8'hFF, 0, 0, 8'h00, 0);
    add(1, 0, 8'hFF, 0, 1, 8'h2E, 0);  // reload from pre-shift S
    add(1, 0, 8'hFF, 0, 0, 8'h2D, 1);
    // Enable hold at 0x05
    add(1, 1, 8'h05, 0, 0, 8'h05, 0);
    add(0, 0, 8'hFF, 1, 0, 8'h05, 0);
    add(0, 1, 8'hFF, 1, 0, 8'h05, 0);
    add(0, 0, 8'h00, 0, 0, 8'h05, 0);
    add(0, 1, 8'hAA, 1, 0, 8'h05, 0);
    add(0, 0, 8'hFF, 1, 0, 8'h05, 0);
    add(1, 0, 8'hFF, 1, 0, 8'h04, 0);
    add(1, 0, 8'hFF, 1, 0, 8'h03, 0);
    add(1, 0, 8'hFF, 1, 0, 8'h02, 0);
    add(1, 0, 8'hFF, 1, 0, 8'h01, 0);
    add(1, 0, 8'hFF, 1, 0, 8'h00, 1);
    // Disabled at zero, then load priority at zero
    add(0, 0, 8'hFF, 0, 0, 8'h00, 1);
    add(1, 1, 8'h10, 0, 0, 8'h10, 0);
    // Load of zero keeps refreshing from the serial stream
    add(1, 1, 8'h00, 1, 0, 8'h00, 0);
    add(1, 0, 8'hFF, 1, 1, 8'h00, 0);
    add(1, 0, 8'hFF, 1, 1, 8'h01, 0);
    add(1, 0, 8'hFF, 1, 0, 8'h00, 0);
    add(1, 0, 8'hFF, 0, 1, 8'h07, 0);

    foreach (vecs[i]) begin
      @(negedge clk);
      en = vecs[i].en; load = vecs[i].load; dta = vecs[i].dta; serin = vecs[i].serin;
      #1;
      chk($sformatf("v%0d_co", i), {7'd0, Co}, {7'd0, vecs[i].co});
      @(posedge clk); #1;
      chk($sformatf("v%0d_q", i), Qo, vecs[i].q);
      chk($sformatf("v%0d_so", i), {7'd0, serout}, {7'd0, vecs[i].so});
    end

    // Async reset between edges with Q = 0x07, serout = 1
    @(negedge clk);
    en = 1'b1; load = 1'b1; dta = 8'h0B; serin = 1'b0;
    @(negedge clk);
    load = 1'b0;
    for (int i = 0; i < 4; i++) @(negedge clk);
    chk("pre_rst_q", Qo, 8'h07);
    chk("pre_rst_so", {7'd0, serout}, 8'h01);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_q", Qo, 8'h00);
    chk("async_rst_so", {7'd0, serout}, 8'h00);
    chk("async_rst_co", {7'd0, Co}, 8'h01);
    @(posedge clk); #1;
    chk("rst_hold_q", Qo, 8'h00);
    rst = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
